// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake and a 2-entry skid buffer (registered in_ready).
// Optional performance counters (stall_cnt, flush_cnt) are enabled by defining IFID_PERF_EN.
module if_id_skid_reg #(
    parameter int unsigned               INSTR_W   = 32,
    parameter int unsigned               ADDR_W    = 64,
    parameter logic [INSTR_W-1:0]        NOP_INSTR = INSTR_W'(32'h00000013)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic [ADDR_W-1:0]  pcplus4_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pcplus4_out
`ifdef IFID_PERF_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t               state_q, state_d;
    logic               in_ready_q;
    logic               accept, consume;
    logic               load_main_in, load_skid_in, load_main_skid;

    logic [INSTR_W-1:0] main_instr_q;
    logic [ADDR_W-1:0]  main_pc_q, main_pc4_q;
    logic [INSTR_W-1:0] skid_instr_q;
    logic [ADDR_W-1:0]  skid_pc_q, skid_pc4_q;

    // in_ready comes from a flop; only reset gates it, never out_ready.
    assign in_ready    = in_ready_q & ~reset;
    assign out_valid   = (state_q != EMPTY);
    assign accept      = in_valid & in_ready;
    assign consume     = out_valid & out_ready;

    assign instr_out   = out_valid ? main_instr_q : NOP_INSTR;
    assign pc_out      = main_pc_q;
    assign pcplus4_out = main_pc4_q;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d      = TWO;
                    load_skid_in = 1'b1;
                end else if (consume) begin
                    state_d      = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Redirect: drop every held beat and any beat arriving this cycle.
        if (flush) begin
            state_d        = EMPTY;
            load_main_in   = 1'b0;
            load_skid_in   = 1'b0;
            load_main_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    // Main entry: pc fields keep their last value once the entry is vacated.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_instr_q <= NOP_INSTR;
            main_pc_q    <= '0;
            main_pc4_q   <= '0;
        end else if (load_main_in) begin
            main_instr_q <= instr_in;
            main_pc_q    <= pc_in;
            main_pc4_q   <= pcplus4_in;
        end else if (load_main_skid) begin
            main_instr_q <= skid_instr_q;
            main_pc_q    <= skid_pc_q;
            main_pc4_q   <= skid_pc4_q;
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid_in) begin
            skid_instr_q <= instr_in;
            skid_pc_q    <= pc_in;
            skid_pc4_q   <= pcplus4_in;
        end
    end

`ifdef IFID_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready)
                stall_cnt_q <= sat_inc(stall_cnt_q);
            if (flush && (state_q != EMPTY))
                flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: directed vector table, randomized run against a queue model,
// and counter checks when IFID_PERF_EN is defined.
module tb_if_id_skid_reg;

    localparam int          IW  = 32;
    localparam int          AW  = 64;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [IW-1:0] instr_in, instr_out;
    logic [AW-1:0] pc_in, pcplus4_in, pc_out, pcplus4_out;
`ifdef IFID_PERF_EN
    logic [31:0]   stall_cnt, flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    if_id_skid_reg #(.INSTR_W(IW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_in(pc_in), .pcplus4_in(pcplus4_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr_out(instr_out), .pc_out(pc_out), .pcplus4_out(pcplus4_out)
`ifdef IFID_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, fl, iv, ordy;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        e_ov, e_ir;
        logic [31:0] e_instr;
        logic [63:0] e_pc, e_pc4;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc, pc4;
    } beat_t;

    vec_t  vecs[$];
    beat_t mq[$];
    logic [63:0] m_pc, m_pc4;

    function automatic vec_t mk(logic rst, logic fl, logic iv, logic ordy, logic [31:0] instr,
                                logic [63:0] pc, logic e_ov, logic e_ir, logic [31:0] e_instr,
                                logic [63:0] e_pc, logic [63:0] e_pc4);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.instr = instr; v.pc = pc;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_instr = e_instr; v.e_pc = e_pc; v.e_pc4 = e_pc4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv, input logic ordy,
                         input logic [31:0] instr, input logic [63:0] pc);
        reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
        instr_in = instr; pc_in = pc; pcplus4_in = pc + 64'd4;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);

        // rst fl iv ordy instr pc | ov ir instr pc pc4
        vecs.push_back(mk(1,0,0,0, 32'h0,        64'h00, 0,0, NOP,          64'h00, 64'h00));
        vecs.push_back(mk(1,0,0,0, 32'h0,        64'h00, 0,0, NOP,          64'h00, 64'h00));
        vecs.push_back(mk(0,0,0,1, 32'h0,        64'h00, 0,1, NOP,          64'h00, 64'h00));
        vecs.push_back(mk(0,0,0,1, 32'h0,        64'h00, 0,1, NOP,          64'h00, 64'h00));
        vecs.push_back(mk(0,0,1,1, 32'h00500093, 64'h00, 1,1, 32'h00500093, 64'h00, 64'h04));
        vecs.push_back(mk(0,0,1,1, 32'h00A00113, 64'h04, 1,1, 32'h00A00113, 64'h04, 64'h08));
        vecs.push_back(mk(0,0,1,1, 32'h002081B3, 64'h08, 1,1, 32'h002081B3, 64'h08, 64'h0C));
        vecs.push_back(mk(0,0,0,1, 32'h0,        64'h00, 0,1, NOP,          64'h08, 64'h0C));
        vecs.push_back(mk(0,0,1,0, 32'h11111111, 64'h10, 1,1, 32'h11111111, 64'h10, 64'h14));
        vecs.push_back(mk(0,0,1,0, 32'h22222222, 64'h14, 1,0, 32'h11111111, 64'h10, 64'h14));
        vecs.push_back(mk(0,0,1,0, 32'h33333333, 64'h18, 1,0, 32'h11111111, 64'h10, 64'h14));
        vecs.push_back(mk(0,0,1,1, 32'h33333333, 64'h18, 1,1, 32'h22222222, 64'h14, 64'h18));
        vecs.push_back(mk(0,0,1,1, 32'h33333333, 64'h18, 1,1, 32'h33333333, 64'h18, 64'h1C));
        vecs.push_back(mk(0,0,0,1, 32'h0,        64'h00, 0,1, NOP,          64'h18, 64'h1C));
        vecs.push_back(mk(0,0,1,0, 32'h44444444, 64'h20, 1,1, 32'h44444444, 64'h20, 64'h24));
        vecs.push_back(mk(0,0,1,0, 32'h55555555, 64'h24, 1,0, 32'h44444444, 64'h20, 64'h24));
        vecs.push_back(mk(0,1,1,0, 32'h66666666, 64'h28, 0,1, NOP,          64'h20, 64'h24));
        vecs.push_back(mk(0,0,0,1, 32'h0,        64'h00, 0,1, NOP,          64'h20, 64'h24));
        vecs.push_back(mk(0,0,1,0, 32'h77777777, 64'h30, 1,1, 32'h77777777, 64'h30, 64'h34));
        vecs.push_back(mk(0,0,1,0, 32'h88888888, 64'h34, 1,0, 32'h77777777, 64'h30, 64'h34));
        vecs.push_back(mk(1,0,1,0, 32'h99999999, 64'h38, 0,0, NOP,          64'h00, 64'h00));
        vecs.push_back(mk(0,0,0,1, 32'h0,        64'h00, 0,1, NOP,          64'h00, 64'h00));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].instr, vecs[i].pc);
            cyc();
            chk($sformatf("vec%0d out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
            chk($sformatf("vec%0d in_ready", i),  {63'd0, in_ready},  {63'd0, vecs[i].e_ir});
            chk($sformatf("vec%0d instr_out", i), {32'd0, instr_out}, {32'd0, vecs[i].e_instr});
            chk($sformatf("vec%0d pc_out", i),    pc_out,             vecs[i].e_pc);
            chk($sformatf("vec%0d pcplus4_out", i), pcplus4_out,      vecs[i].e_pc4);
        end

        // Randomized run against a FIFO model of capacity two; register is EMPTY with pc 0 here.
        mq.delete();
        m_pc  = 64'h0;
        m_pc4 = 64'h0;
        for (int n = 0; n < 600; n++) begin
            logic        iv, ordy, fl, acc, con;
            logic [31:0] ins;
            logic [63:0] pc;
            beat_t       b;
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 5);
            fl   = ($urandom_range(0, 15) == 0);
            ins  = $urandom;
            pc   = {32'd0, $urandom} & 64'hFFFF_FFFC;
            drive(1'b0, fl, iv, ordy, ins, pc);
            acc = iv && (mq.size() < 2);
            con = ordy && (mq.size() > 0);
            cyc();
            if (fl) begin
                mq.delete();
            end else begin
                if (con) void'(mq.pop_front());
                if (acc) begin
                    b.instr = ins; b.pc = pc; b.pc4 = pc + 64'd4;
                    mq.push_back(b);
                end
            end
            if (mq.size() > 0) begin
                m_pc  = mq[0].pc;
                m_pc4 = mq[0].pc4;
            end
            chk("rnd out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
            chk("rnd in_ready",  {63'd0, in_ready},  {63'd0, mq.size() < 2});
            chk("rnd instr_out", {32'd0, instr_out}, {32'd0, (mq.size() > 0) ? mq[0].instr : NOP});
            chk("rnd pc_out",      pc_out,      m_pc);
            chk("rnd pcplus4_out", pcplus4_out, m_pc4);
        end

`ifdef IFID_PERF_EN
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0); cyc();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hABCD0001, 64'h100); cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
        for (int k = 0; k < 7; k++) cyc();
        chk("perf stall_cnt 7", {32'd0, stall_cnt}, 64'd7);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 64'h0); cyc();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 64'h0); cyc();
        chk("perf flush_cnt empty", {32'd0, flush_cnt}, 64'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hABCD0002, 64'h200); cyc();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hABCD0003, 64'h204); cyc();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'hABCD0004, 64'h208); cyc();
        chk("perf flush_cnt two", {32'd0, flush_cnt}, 64'd1);
        chk("perf flush out_valid", {63'd0, out_valid}, 64'd0);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt_q;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hABCD0005, 64'h300); cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0); cyc();
        chk("perf stall_cnt sat", {32'd0, stall_cnt}, 64'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
